lut_rd_arbiter: RTL
===================

LUT_RD_ARBITER -- requirements
Module: lut_rd_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the lookup-ROM and requester address width.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the lookup-ROM read data width.
REQ-003 Parameter ROM_LATENCY, default 1, legal 1 or 2, SHALL equal the ROM read latency in clocks: 1 without output register, 2 with output register.
REQ-004 clk  input  1  single clock for all logic, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  3  per-requester read request; bit i belongs to requester i.
REQ-007 req_addr0, req_addr1, req_addr2  input  ADDR_WIDTH each  requester addresses; each SHALL be held stable while its valid is high and it is not yet accepted.
REQ-008 req_ready  output  3  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 rom_addr  output  ADDR_WIDTH  address to the shared single-port lookup ROM.
REQ-010 rom_rd_data  input  DATA_WIDTH  ROM read data.
REQ-011 rsp_valid  output  3  one-hot response strobe, one cycle per accepted request.
REQ-012 rsp_data  output  DATA_WIDTH  response data shared by all requesters, qualified by rsp_valid.
REQ-013 busy  output  1  high while any accepted request has not yet responded.

Function
REQ-014 Grant: at most one req_ready bit high per cycle; req_ready SHALL be combinational from req_valid and the priority pointer; all bits low when req_valid is 0.
REQ-015 Arbitration: round-robin; the search starts at the pointer, and after a transfer by requester i the pointer SHALL become (i+1) mod 3; with no transfer the pointer SHALL hold.
REQ-016 Fairness: a continuously valid requester SHALL be granted within 3 cycles of raising valid.
REQ-017 rom_addr SHALL be the granted requester's address in the transfer cycle; in cycles without a transfer it SHALL hold its last value.
REQ-018 Tag pipeline: a ROM_LATENCY-deep shift register SHALL carry the one-hot grant, advancing every cycle.
REQ-019 Latency: a transfer by requester i in cycle T SHALL produce rsp_valid[i]=1 in cycle T+ROM_LATENCY, with rsp_data equal to rom_rd_data of that cycle.
REQ-020 rsp_data SHALL pass rom_rd_data combinationally; it is undefined whenever rsp_valid is 0.
REQ-021 Throughput: one transfer per cycle is sustained; responses have no backpressure and the consumer SHALL always accept them.
REQ-022 Ordering: responses SHALL return in acceptance order.
REQ-023 A requester may re-request in the cycle its response arrives or earlier.
REQ-024 busy SHALL equal the OR of all tag-pipeline stages.

Reset
REQ-025 While rst_n is low: req_ready=0, rsp_valid=0, busy=0, rom_addr=0, tag pipeline cleared, pointer=0.
REQ-026 If reset is asserted mid-operation, in-flight requests SHALL be discarded and no rsp_valid SHALL be issued for them after release.
REQ-027 The first grant SHALL be possible in the first clock edge after rst_n deasserts.

Configuration
REQ-028 Macro LUT_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority, requester 0 highest and requester 2 lowest, the pointer SHALL be removed, and REQ-016 SHALL not apply.
REQ-029 Without LUT_ARB_FIXED_PRIO_EN, the round-robin behaviour of REQ-015 and REQ-016 SHALL apply.

Verification
REQ-030 Single request, ROM_LATENCY=1: req_valid=001, addr0=0x005 -> req_ready=001 same cycle; rom_addr=0x005; next cycle rsp_valid=001, rsp_data=ROM[0x005].
REQ-031 All three valid continuously, addresses 0x010/0x020/0x030 -> grants cycle 0,1,2 in order; responses in the same order with ROM values; repeats without gaps.
REQ-032 ROM_LATENCY=2, back-to-back 001 then 100 -> rsp_valid=001 at T+2, then 100 at T+3; busy high from T+1 to T+3.
REQ-033 Reset pulse one cycle after a transfer -> rsp_valid stays 000; pointer=0 after release; first grant on the next valid.
REQ-034 Idle after a transfer from requester 1 -> rom_addr holds its value; the next simultaneous 111 request is granted to requester 2 first.
REQ-035 With LUT_ARB_FIXED_PRIO_EN and req_valid=011 held -> requester 0 is granted every cycle and requester 1 is never granted.

Source files
------------

// File: rtl/lut_rd_arbiter.sv
// Three-requester read arbiter in front of a shared single-port lookup ROM with tagged responses.
// Define LUT_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module lut_rd_arbiter #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [ADDR_WIDTH-1:0] req_addr2,
    output logic [2:0]            req_ready,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic [2:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy
);

    logic [2:0]                         w_grant;
    logic                               w_xfer;
    logic [ADDR_WIDTH-1:0]              r_last_addr;
    logic [ROM_LATENCY-1:0][2:0]        r_tag;

`ifdef LUT_ARB_FIXED_PRIO_EN
    always_comb begin
        w_grant = 3'b000;
        if (req_valid[0])      w_grant = 3'b001;
        else if (req_valid[1]) w_grant = 3'b010;
        else if (req_valid[2]) w_grant = 3'b100;
    end
`else
    logic [1:0] r_ptr;

    // Rotate so the pointed-to requester sits at bit 0, take the lowest set bit, rotate back.
    function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] p);
        logic [2:0] rot;
        logic [2:0] pick;
        case (p)
            2'd1:    rot = {v[0], v[2:1]};
            2'd2:    rot = {v[1:0], v[2]};
            default: rot = v;
        endcase
        if (rot[0])      pick = 3'b001;
        else if (rot[1]) pick = 3'b010;
        else if (rot[2]) pick = 3'b100;
        else             pick = 3'b000;
        case (p)
            2'd1:    return {pick[1:0], pick[2]};
            2'd2:    return {pick[0], pick[2:1]};
            default: return pick;
        endcase
    endfunction

    always_comb w_grant = rr_pick(req_valid, r_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 2'd0;
        end else if (w_xfer) begin
            case (req_ready)
                3'b001:  r_ptr <= 2'd1;
                3'b010:  r_ptr <= 2'd2;
                default: r_ptr <= 2'd0;
            endcase
        end
    end
`endif

    // Grants are suppressed while reset is held so nothing is accepted that would be lost.
    assign req_ready = rst_n ? w_grant : 3'b000;
    assign w_xfer    = |req_ready;

    always_comb begin
        case (req_ready)
            3'b001:  rom_addr = req_addr0;
            3'b010:  rom_addr = req_addr1;
            3'b100:  rom_addr = req_addr2;
            default: rom_addr = r_last_addr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_addr <= '0;
        end else if (w_xfer) begin
            r_last_addr <= rom_addr;
        end
    end

    // The one-hot grant rides alongside the ROM access and emerges with its data.
    generate
        if (ROM_LATENCY > 1) begin : g_tag_deep
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag <= '0;
                end else begin
                    r_tag <= {r_tag[ROM_LATENCY-2:0], req_ready};
                end
            end
        end else begin : g_tag_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag <= '0;
                end else begin
                    r_tag <= req_ready;
                end
            end
        end
    endgenerate

    assign rsp_valid = r_tag[ROM_LATENCY-1];
    assign rsp_data  = rom_rd_data;
    assign busy      = |r_tag;

endmodule
